spi_reg_ctrl: RTL
=================

Name: spi_reg_ctrl

Overview:
Register-access controller sequencing the synchronized SPI slave strobes from spi_sync (spi_start, spi_sck_rising/falling, spi_busy, mosi_out). It decodes a command byte, then streams burst writes into, or burst reads out of, an internal register bank with address auto-increment. It drives miso and one-cycle register strobes in the clk domain. The parent instantiates spi_sync and this block side by side.

Parameters:
ADDR_W, 7, register address width; command byte = {rnw, addr[6:0]}, so fixed at 7 for 8-bit frames.
DATA_W, 8, data byte width; only 8 supported.
AUTO_INC, 1, 1 = address increments after each data byte; 0 = address held for the whole frame.

Ports:
clk  in  1  system clock, same clock as spi_sync
rst_n  in  1  asynchronous active-low reset
spi_start  in  1  ncs falling-edge strobe (1 cycle)
spi_sck_rising  in  1  sck rising strobe, ncs asserted (1 cycle)
spi_sck_falling  in  1  sck falling strobe, ncs asserted (1 cycle)
spi_busy  in  1  high from ncs low until frame ends
mosi  in  1  synchronized MOSI (spi_sync mosi_out)
miso  out  1  serial read data, MSB first
reg_addr  out  ADDR_W  address for current we/re strobe
reg_wdata  out  DATA_W  write data, valid with reg_we
reg_we  out  1  write strobe, 1 cycle
reg_re  out  1  read request, 1 cycle; reg_rdata sampled exactly 1 cycle later
reg_rdata  in  DATA_W  read data from register bank
frame_done  out  1  1-cycle pulse at end of every frame
frame_err  out  1  1-cycle pulse with frame_done if the frame ended mid-byte

Behaviour:
- Reset (rst_n low, async): state IDLE; miso, reg_addr, reg_wdata, reg_we, reg_re, frame_done, frame_err, bit counter and shift registers all 0.
- SPI mode 0, MSB first: mosi sampled on spi_sck_rising; miso updated on spi_sck_falling.
- States: IDLE, CMD, WR_DATA, RD_DATA.
- IDLE -> CMD on spi_start: clear bit_cnt (3 bits) and rx shift register.
- From any state, spi_start restarts to CMD and clears bit_cnt. It has priority over a same-cycle rising or falling strobe, which is ignored. No we/re is issued for the aborted byte.
- Each rising strobe: rx <= {rx[6:0], mosi}; bit_cnt++ (wraps 7 -> 0). The byte is complete on the strobe where bit_cnt == 7.
- CMD byte complete: addr <= byte[6:0].
  - byte[7] = 0: go to WR_DATA.
  - byte[7] = 1: go to RD_DATA; next cycle reg_re = 1 with reg_addr = addr.
- WR_DATA byte complete: next cycle reg_we = 1, reg_wdata = byte, reg_addr = addr. The cycle after, addr increments if AUTO_INC.
- RD_DATA:
  - Every completed byte (dummy MOSI) issues reg_re for the next address: addr increments first if AUTO_INC.
  - reg_rdata is captured into tx shift register 2 cycles after the completing rising strobe.
  - spi_sync guarantees sck half-period >= 5 clk, so the load always precedes the next falling strobe.
- Each falling strobe in RD_DATA: miso <= tx[7]; tx <= tx << 1. miso is 0 in IDLE, CMD and WR_DATA.
- Address arithmetic is modulo 2^ADDR_W: 127 -> 0.
- End of frame: spi_busy 1 -> 0 (registered edge detect). Go to IDLE and pulse frame_done. frame_err = 1 in the same cycle if bit_cnt != 0. miso returns to 0.
- A pending we/re from a byte completed before busy fell is still issued; the partial byte is discarded.
- Strobes arriving in IDLE without spi_start are ignored.

Decomposition:
- Shared package spi_pkg: state enum (IDLE, CMD, WR_DATA, RD_DATA), CMD_RNW_BIT = 7, SPI_BYTE_W = 8.
- No sub-module: one FSM plus counter and two shift registers; spi_sync stays a sibling instance in the parent.

Test Plan:
- Write burst: ncs low, send 0x05, 0xA1, 0xB2, raise ncs -> reg_we at addr 0x05 data 0xA1, then addr 0x06 data 0xB2; frame_done = 1, frame_err = 0.
- Read burst: bank[0x10] = 0x3C, bank[0x11] = 0xC3; send 0x90 then 2 dummy bytes -> reg_re at 0x10 then 0x11; miso bytes 0x3C, 0xC3.
- Wrap: write cmd 0x7F, 2 data bytes -> writes land at 0x7F then 0x00.
- Partial byte: cmd 0x02, then 5 bits, ncs high -> no reg_we; frame_done = 1 with frame_err = 1; state IDLE.
- Restart: spi_start after 3 bits of a data byte, then cmd 0x81 -> aborted byte dropped, reg_re at 0x01.
- Reset mid-frame: rst_n low during RD_DATA -> all outputs 0 immediately; next frame decodes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI register-access controller.
//   spi_state_e  : controller FSM states
//   CMD_RNW_BIT  : bit of the command byte selecting read (1) or write (0)
//   SPI_BYTE_W   : bits per SPI byte
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_DATA
    } spi_state_e;

    localparam int unsigned CMD_RNW_BIT = 7;
    localparam int unsigned SPI_BYTE_W  = 8;

endpackage

// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
// Register-access controller behind spi_sync. Decodes a command byte
// {rnw, addr[6:0]}, then streams burst writes into or burst reads out of a
// register bank with optional address auto-increment. SPI mode 0, MSB first.
//
// Ports
//   clk, rst_n        : system clock, async active-low reset
//   spi_start         : ncs falling-edge strobe (restarts the frame)
//   spi_sck_rising    : sck rising strobe, mosi sampled here
//   spi_sck_falling   : sck falling strobe, miso updated here
//   spi_busy          : high for the duration of a frame
//   mosi              : synchronized MOSI
//   miso              : serial read data, MSB first
//   reg_addr          : address for the current reg_we/reg_re strobe
//   reg_wdata         : write data, valid with reg_we
//   reg_we            : one-cycle write strobe
//   reg_re            : one-cycle read request; reg_rdata sampled 1 cycle later
//   reg_rdata         : read data from the register bank
//   frame_done        : one-cycle pulse at the end of every frame
//   frame_err         : pulses with frame_done when the frame ended mid-byte
// -----------------------------------------------------------------------------
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8,    // only 8 supported
    parameter bit          AUTO_INC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_start,
    input  logic              spi_sck_rising,
    input  logic              spi_sck_falling,
    input  logic              spi_busy,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int unsigned BitCntW = $clog2(SPI_BYTE_W);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(SPI_BYTE_W - 1);

    spi_state_e          r_state,    w_state_d;
    logic [BitCntW-1:0]  r_bit_cnt,  w_bit_cnt_d;
    logic [DATA_W-1:0]   r_rx,       w_rx_d;
    logic [DATA_W-1:0]   r_tx,       w_tx_d;
    logic [ADDR_W-1:0]   r_addr,     w_addr_d;
    logic                r_miso,     w_miso_d;
    logic [ADDR_W-1:0]   r_reg_addr, w_reg_addr_d;
    logic [DATA_W-1:0]   r_reg_wdata, w_reg_wdata_d;
    logic                r_reg_we,   w_reg_we_d;
    logic                r_reg_re,   w_reg_re_d;
    logic                r_done,     w_done_d;
    logic                r_err,      w_err_d;
    logic                r_busy_q;
    logic                r_re_q;     // reg_re delayed: reg_rdata is valid now

    logic [DATA_W-1:0]   w_byte;
    logic [ADDR_W-1:0]   w_addr_next;
    logic                w_busy_fall;

    assign w_byte      = {r_rx[DATA_W-2:0], mosi};
    assign w_addr_next = AUTO_INC ? r_addr + ADDR_W'(1) : r_addr;
    assign w_busy_fall = r_busy_q & ~spi_busy;

    always_comb begin
        w_state_d     = r_state;
        w_bit_cnt_d   = r_bit_cnt;
        w_rx_d        = r_rx;
        w_tx_d        = r_tx;
        w_addr_d      = r_addr;
        w_miso_d      = r_miso;
        w_reg_addr_d  = r_reg_addr;
        w_reg_wdata_d = r_reg_wdata;
        w_reg_we_d    = 1'b0;
        w_reg_re_d    = 1'b0;
        w_done_d      = 1'b0;
        w_err_d       = 1'b0;

        // Read data arrives two cycles after the completing strobe; the sck
        // half-period guarantees no falling strobe collides with this load.
        if (r_re_q) begin
            w_tx_d = reg_rdata;
        end

        if (spi_start) begin
            // Restart wins over any same-cycle sck strobe; partial byte dropped.
            w_state_d   = CMD;
            w_bit_cnt_d = '0;
            w_rx_d      = '0;
            w_miso_d    = 1'b0;
        end else if (w_busy_fall) begin
            w_state_d   = IDLE;
            w_done_d    = 1'b1;
            w_err_d     = (r_bit_cnt != '0);
            w_bit_cnt_d = '0;
            w_rx_d      = '0;
            w_miso_d    = 1'b0;
        end else if (r_state != IDLE) begin
            if (spi_sck_rising) begin
                w_rx_d      = w_byte;
                w_bit_cnt_d = r_bit_cnt + BitCntW'(1);
                if (r_bit_cnt == LastBit) begin
                    case (r_state)
                        CMD: begin
                            w_addr_d = w_byte[ADDR_W-1:0];
                            if (w_byte[CMD_RNW_BIT]) begin
                                w_state_d    = RD_DATA;
                                w_reg_re_d   = 1'b1;
                                w_reg_addr_d = w_byte[ADDR_W-1:0];
                            end else begin
                                w_state_d = WR_DATA;
                            end
                        end
                        WR_DATA: begin
                            // reg_addr latches the current address, so the
                            // increment can land on the same edge.
                            w_reg_we_d    = 1'b1;
                            w_reg_wdata_d = w_byte;
                            w_reg_addr_d  = r_addr;
                            w_addr_d      = w_addr_next;
                        end
                        RD_DATA: begin
                            // Prefetch the byte shifted out during the next byte.
                            w_addr_d     = w_addr_next;
                            w_reg_addr_d = w_addr_next;
                            w_reg_re_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            if (spi_sck_falling) begin
                if (r_state == RD_DATA) begin
                    w_miso_d = r_tx[DATA_W-1];
                    w_tx_d   = {r_tx[DATA_W-2:0], 1'b0};
                end else begin
                    w_miso_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_addr      <= '0;
            r_miso      <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy_q    <= 1'b0;
            r_re_q      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_rx        <= w_rx_d;
            r_tx        <= w_tx_d;
            r_addr      <= w_addr_d;
            r_miso      <= w_miso_d;
            r_reg_addr  <= w_reg_addr_d;
            r_reg_wdata <= w_reg_wdata_d;
            r_reg_we    <= w_reg_we_d;
            r_reg_re    <= w_reg_re_d;
            r_done      <= w_done_d;
            r_err       <= w_err_d;
            r_busy_q    <= spi_busy;
            r_re_q      <= r_reg_re;
        end
    end

    assign miso       = r_miso;
    assign reg_addr   = r_reg_addr;
    assign reg_wdata  = r_reg_wdata;
    assign reg_we     = r_reg_we;
    assign reg_re     = r_reg_re;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule
